// File: rtl/minimig_rstseq_pkg.sv
// minimig_rstseq_pkg: shared types and constants for the reset sequencer.
package minimig_rstseq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_MRST = 2'd1;
  localparam logic [1:0] CAUSE_BOOT = 2'd2;
  localparam logic [1:0] CAUSE_WDOG = 2'd3;

  localparam int WDOG_W = 16;

  // Bits needed to hold 0..maxv (at least one bit).
  function automatic int cnt_width(input int maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/minimig_rstseq_chan.sv
// minimig_rstseq_chan: one reset domain -- rst_out bit plus soft-reset stretch counter.
// Priority inside an enabled cycle: force_rst > release_rst > req > soft countdown.
module minimig_rstseq_chan
  import minimig_rstseq_pkg::*;
#(
  parameter int SOFT_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic force_rst,
  input  logic release_rst,
  input  logic req,
  input  logic soft_run,
  input  logic cnt_en,
  output logic rst_out
);

  localparam int SW = cnt_width(SOFT_LEN);

  logic          rst_q, rst_d;
  logic [SW-1:0] soft_q, soft_d;

  // Next-state: full reset, staged release, or soft reset stretched SOFT_LEN pulses past req drop.
  always_comb begin
    rst_d  = rst_q;
    soft_d = soft_q;
    if (en) begin
      if (force_rst) begin
        rst_d  = 1'b1;
        soft_d = '0;
      end else if (release_rst) begin
        rst_d  = 1'b0;
        soft_d = '0;
      end else if (req) begin
        rst_d  = 1'b1;
        soft_d = SW'(SOFT_LEN);
      end else if (soft_run && rst_q && cnt_en) begin
        if (soft_q <= SW'(1)) begin
          rst_d  = 1'b0;
          soft_d = '0;
        end else begin
          soft_d = soft_q - SW'(1);
        end
      end
    end
  end

  // State registers; domain comes out of reset held.
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_q  <= 1'b1;
      soft_q <= '0;
    end else begin
      rst_q  <= rst_d;
      soft_q <= soft_d;
    end
  end

  assign rst_out = rst_q;

endmodule

// File: rtl/minimig_rstseq.sv
// minimig_rstseq: multi-domain reset sequencer (hold, staggered release, boot tracking,
// per-channel soft resets, reset cause). Optional watchdog: define MINIMIG_RSTSEQ_WDOG_EN.
module minimig_rstseq
  import minimig_rstseq_pkg::*;
#(
  parameter int CNT_W    = 3,
  parameter int NCH      = 4,
  parameter int STAGGER  = 2,
  parameter int SOFT_LEN = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clk7_en,
  input  logic           cnt,
  input  logic           mrst,
  input  logic           bootdone,
  input  logic [NCH-1:0] chan_req,
  input  logic           wdog_kick,
  output logic [NCH-1:0] rst_out,
  output logic           boot,
  output logic           ready,
  output logic [1:0]     cause
);

  localparam int HOLD    = 2 ** (CNT_W - 1);
  localparam int STG_MAX = (NCH - 1) * STAGGER;
  localparam int SGW     = cnt_width(STG_MAX);

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic             boot_q, boot_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [SGW-1:0]   stg_q, stg_d, stg_next;
  logic [1:0]       mrst_sync_q, mrst_sync_d;
  logic             smrst, boot_trig, wdog_fire, force_all, soft_run;
  logic [NCH-1:0]   rel;

  assign smrst     = mrst_sync_q[1];
  assign boot_trig = (state_q == ST_RUN) && boot_q && bootdone;
  assign soft_run  = (state_q == ST_RUN);
  assign stg_next  = (stg_q >= SGW'(STG_MAX)) ? stg_q : stg_q + SGW'(1);

  // Two-stage synchroniser for the asynchronous master reset, advancing on enabled cycles only.
  always_comb begin
    mrst_sync_d = mrst_sync_q;
    if (clk7_en) mrst_sync_d = {mrst_sync_q[0], mrst};
  end

`ifdef MINIMIG_RSTSEQ_WDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Watchdog fires on the pulse that would bring the count to all-ones; armed only in RUN.
  always_comb begin
    wdog_fire = clk7_en && (state_q == ST_RUN) && !smrst && !wdog_kick && cnt &&
                (wdog_q == {{(WDOG_W-1){1'b1}}, 1'b0});
    wdog_d = wdog_q;
    if (clk7_en) begin
      if (state_q != ST_RUN || smrst || wdog_fire || boot_trig || wdog_kick) wdog_d = '0;
      else if (cnt && wdog_q != '1) wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  logic unused_wdog_kick;
  assign unused_wdog_kick = wdog_kick;
  assign wdog_fire        = 1'b0;
`endif

  // Sequencer next-state: full-reset causes by priority, then hold / staggered release.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    boot_d    = boot_q;
    hold_d    = hold_q;
    stg_d     = stg_q;
    rel       = '0;
    force_all = 1'b0;
    if (clk7_en) begin
      if (smrst || wdog_fire || boot_trig) begin
        state_d   = ST_ASSERT;
        force_all = 1'b1;
        hold_d    = '0;
        stg_d     = '0;
        cause_d   = smrst ? CAUSE_MRST : (wdog_fire ? CAUSE_WDOG : CAUSE_BOOT);
      end else begin
        unique case (state_q)
          ST_ASSERT: begin
            force_all = 1'b1;
            hold_d    = '0;
            stg_d     = '0;
            state_d   = ST_HOLD;
          end
          ST_HOLD: begin
            if (cnt) begin
              if (hold_q == CNT_W'(HOLD - 1)) begin
                state_d = ST_RELEASE;
                stg_d   = '0;
                for (int i = 0; i < NCH; i++)
                  if (i * STAGGER == 0) rel[i] = 1'b1;
              end else begin
                hold_d = hold_q + CNT_W'(1);
              end
            end
          end
          ST_RELEASE: begin
            if (stg_q >= SGW'(STG_MAX)) begin
              state_d = ST_RUN;
              // The sequence started by bootdone ends the boot phase.
              if (cause_q == CAUSE_BOOT) boot_d = 1'b0;
            end else if (cnt) begin
              stg_d = stg_next;
              for (int i = 0; i < NCH; i++)
                if (int'(stg_next) >= i * STAGGER) rel[i] = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
    ready_d = (state_d == ST_RUN);
  end

  // Sequencer registers with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ASSERT;
      cause_q     <= CAUSE_POR;
      boot_q      <= 1'b1;
      ready_q     <= 1'b0;
      hold_q      <= '0;
      stg_q       <= '0;
      mrst_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      boot_q      <= boot_d;
      ready_q     <= ready_d;
      hold_q      <= hold_d;
      stg_q       <= stg_d;
      mrst_sync_q <= mrst_sync_d;
    end
  end

  minimig_rstseq_chan #(.SOFT_LEN(SOFT_LEN)) u_chan [NCH-1:0] (
    .clk         (clk),
    .reset       (reset),
    .en          (clk7_en),
    .force_rst   (force_all),
    .release_rst (rel),
    .req         (chan_req & {NCH{soft_run}}),
    .soft_run    (soft_run),
    .cnt_en      (cnt),
    .rst_out     (rst_out)
  );

  assign boot  = boot_q;
  assign ready = ready_q;
  assign cause = cause_q;

endmodule

// File: tb/tb_minimig_rstseq.sv
// tb_minimig_rstseq: randomized bench against a pulse-count reference model.
module tb_minimig_rstseq;

  localparam int NCH      = 4;
  localparam int HOLD     = 4;
  localparam int STAGGER  = 2;
  localparam int SOFT_LEN = 2;
  localparam int LAST     = HOLD + (NCH - 1) * STAGGER;

  logic           clk = 1'b0;
  logic           reset, clk7_en, cnt, mrst, bootdone, wdog_kick;
  logic [NCH-1:0] chan_req;
  logic [NCH-1:0] rst_out;
  logic           boot, ready;
  logic [1:0]     cause;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: sequence position measured in cnt pulses since leaving ASSERT.
  bit m_assert, m_run, m_boot, m_s1, m_s2;
  int m_pulses, m_cause;
  bit m_soft_on [NCH];
  int m_soft_left [NCH];

  minimig_rstseq #(.CNT_W(3), .NCH(NCH), .STAGGER(STAGGER), .SOFT_LEN(SOFT_LEN)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .cnt(cnt), .mrst(mrst),
    .bootdone(bootdone), .chan_req(chan_req), .wdog_kick(wdog_kick),
    .rst_out(rst_out), .boot(boot), .ready(ready), .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int want);
    n_chk++;
    if (obs == want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, want, $time);
  endtask

  task automatic m_full(input int c);
    m_assert = 1; m_pulses = 0; m_run = 0; m_cause = c;
    for (int i = 0; i < NCH; i++) begin m_soft_on[i] = 0; m_soft_left[i] = 0; end
  endtask

  task automatic model_step();
    bit smr;
    if (reset) begin
      m_full(0); m_boot = 1; m_s1 = 0; m_s2 = 0;
      return;
    end
    if (!clk7_en) return;
    smr = m_s2; m_s2 = m_s1; m_s1 = mrst;
    if (smr) m_full(1);
    else if (m_run && m_boot && bootdone) m_full(2);
    else if (m_assert) begin
      m_assert = 0; m_pulses = 0;
    end else if (!m_run) begin
      if (m_pulses >= LAST) begin
        m_run = 1;
        if (m_cause == 2) m_boot = 0;
      end else m_pulses += int'(cnt);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (chan_req[i]) begin
          m_soft_on[i] = 1; m_soft_left[i] = SOFT_LEN;
        end else if (m_soft_on[i] && cnt) begin
          if (m_soft_left[i] <= 1) begin m_soft_on[i] = 0; m_soft_left[i] = 0; end
          else m_soft_left[i]--;
        end
      end
    end
  endtask

  function automatic int m_rst();
    int v = 0;
    for (int i = 0; i < NCH; i++)
      if (m_run ? m_soft_on[i] : (m_assert || m_pulses < HOLD + i * STAGGER)) v |= (1 << i);
    return v;
  endfunction

  // One clock: DUT and model see the same inputs; outputs compared 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("rst_out", int'(rst_out), m_rst());
    chk("ready", int'(ready), int'(m_run));
    chk("boot", int'(boot), int'(m_boot));
    chk("cause", int'(cause), m_cause);
  endtask

  task automatic idle_inputs();
    mrst = 0; bootdone = 0; chan_req = '0; wdog_kick = 0;
  endtask

  initial begin
    int n;
    int mrst_hold;
    int req_hold [NCH];
    reset = 1; clk7_en = 1; cnt = 1; idle_inputs();
    #1;
    cyc(); cyc();

    // Power-on sequence with a pulse every enabled cycle.
    reset = 0;
    n = 0;
    while (!ready && n < 40) begin cyc(); n++; end
    chk("por_ready_cycle", n, 12);
    chk("por_boot", int'(boot), 1);

    // bootdone in RUN re-runs the sequence and ends the boot phase.
    bootdone = 1; cyc(); bootdone = 0;
    chk("boot_reassert", int'(rst_out), 'hF);
    repeat (14) cyc();
    chk("boot_done_boot", int'(boot), 0);
    chk("boot_done_cause", int'(cause), 2);

    // Second bootdone is ignored.
    bootdone = 1; cyc(); bootdone = 0;
    chk("boot_second_ready", int'(ready), 1);

    // Soft reset on channel 2.
    chan_req = 4'b0100; repeat (3) cyc(); chan_req = '0;
    chk("soft_held", int'(rst_out), 'h4);
    repeat (3) cyc();

    // Disabled clock: cnt toggles, nothing moves.
    clk7_en = 0; mrst = 1;
    for (int k = 0; k < 10; k++) begin cnt = ~cnt; cyc(); end
    mrst = 0; clk7_en = 1; cnt = 1;
    chk("en_low_ready", int'(ready), 1);

    // Master reset during RELEASE.
    mrst = 1; cyc(); mrst = 0;
    n = 0;
    while (rst_out != 4'b1100 && n < 40) begin cyc(); n++; end
    mrst = 1; cyc(); cyc(); cyc();
    chk("mrst_reassert", int'(rst_out), 'hF);
    chk("mrst_cause", int'(cause), 1);
    repeat (5) cyc();
    mrst = 0;

    // Randomized traffic.
    mrst_hold = 0;
    for (int i = 0; i < NCH; i++) req_hold[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 499) == 0);
      clk7_en   = ($urandom_range(0, 3) != 0);
      cnt       = ($urandom_range(0, 4) < 3);
      bootdone  = ($urandom_range(0, 29) == 0);
      wdog_kick = $urandom_range(0, 1);
      if (mrst_hold > 0) mrst_hold--;
      else if ($urandom_range(0, 79) == 0) mrst_hold = $urandom_range(1, 6);
      mrst = (mrst_hold > 0);
      for (int i = 0; i < NCH; i++) begin
        if (req_hold[i] > 0) req_hold[i]--;
        else if ($urandom_range(0, 39) == 0) req_hold[i] = $urandom_range(1, 4);
        chan_req[i] = (req_hold[i] > 0);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
